// File: rtl/mix_columns_engine.sv
// mix_columns_engine: AES MixColumns / InvMixColumns over a 128-bit state.
// A state is captured in IDLE and transformed in place, COLS_PER_CYCLE
// columns per BUSY cycle with column 0 first. The result is then held in
// DONE until downstream takes it.
// Optional feature: define MIX_COLUMNS_INV_EN to build the inverse datapath.
// Without that macro, inv is ignored and every state gets forward MixColumns.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE and out_valid is 1 only in DONE. Once
// out_valid is raised, mixed_data stays stable until the out_ready transfer.
// state_dbg exposes the FSM state for observation.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [127:0] inp_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] mixed_data,
    output logic [1:0]   state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Column index advance per BUSY cycle; the counter reaches 4 on the last one.
    localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

    state_t       state_q, state_d;
    logic [127:0] data_q, data_d;
    logic [2:0]   col_q, col_d;

    // Multiply a byte by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward column: circulant matrix [02 03 01 01].
    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    logic inv_q, inv_d;

    // Products by 09, 0b, 0d, 0e built from the x2/x4/x8 chain.
    function automatic logic [7:0] m9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction
    function automatic logic [7:0] mb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction
    function automatic logic [7:0] md(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction
    function automatic logic [7:0] me(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // Inverse column: circulant matrix [0e 0b 0d 09].
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3),
                m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3),
                md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3),
                mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3)};
    endfunction
`else
    // inv has no effect in a forward-only build.
    logic unused_inv;
    assign unused_inv = inv;
`endif

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        col_d     = col_q;
`ifdef MIX_COLUMNS_INV_EN
        inv_d     = inv_q;
`endif
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = inp_data;
`ifdef MIX_COLUMNS_INV_EN
                    inv_d   = inv;
`endif
                    col_d   = 3'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int c = 0; c < 4; c++) begin
                    if ((3'(c) >= col_q) && (3'(c) < col_q + STEP)) begin
`ifdef MIX_COLUMNS_INV_EN
                        data_d[127-32*c -: 32] = inv_q ? inv_col(data_q[127-32*c -: 32])
                                                       : fwd_col(data_q[127-32*c -: 32]);
`else
                        data_d[127-32*c -: 32] = fwd_col(data_q[127-32*c -: 32]);
`endif
                    end
                end
                col_d = col_q + STEP;
                if (col_q + STEP == 3'd4) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, column counter and state register; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            col_q   <= 3'd0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            col_q   <= col_d;
`ifdef MIX_COLUMNS_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign mixed_data = data_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: three engines (1, 2 and 4 columns per cycle) checked
// against a GF(2^8) matrix model, using table vectors, random states and
// hand-written handshake/reset sequences.
module tb_mix_columns_engine;

`ifdef MIX_COLUMNS_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid   [3];
    logic         in_ready   [3];
    logic         inv_s      [3];
    logic [127:0] inp_data   [3];
    logic         out_valid  [3];
    logic         out_ready  [3];
    logic [127:0] mixed_data [3];
    logic [1:0]   state_dbg  [3];

    int cpc_of [3] = '{1, 2, 4};

    mix_columns_engine #(.COLS_PER_CYCLE(1)) u_c1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .inv(inv_s[0]), .inp_data(inp_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .mixed_data(mixed_data[0]), .state_dbg(state_dbg[0]));
    mix_columns_engine #(.COLS_PER_CYCLE(2)) u_c2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .inv(inv_s[1]), .inp_data(inp_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .mixed_data(mixed_data[1]), .state_dbg(state_dbg[1]));
    mix_columns_engine #(.COLS_PER_CYCLE(4)) u_c4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .inv(inv_s[2]), .inp_data(inp_data[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .mixed_data(mixed_data[2]), .state_dbg(state_dbg[2]));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Row r of the circulant matrix uses coefficient coef[(k - r) mod 4] for byte k.
    function automatic logic [127:0] ref_mix(input logic [127:0] d, input logic use_inv);
        logic [7:0]   coef [4];
        logic [127:0] res;
        logic [7:0]   acc;
        if (use_inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(coef[(k - r + 4) % 4], d[127-32*c-8*k -: 8]);
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic iv);
        return ref_mix(d, iv && INV_EN);
    endfunction

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [127:0] exp_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Offer a state at a falling edge; returns at the falling edge after the accept edge.
    task automatic send(input int idx, input logic [127:0] d, input logic iv);
        int t;
        t = 0;
        while (!in_ready[idx] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check_int("send_timeout", 1, 0);
        in_valid[idx] = 1'b1;
        inp_data[idx] = d;
        inv_s[idx]    = iv;
        @(posedge clk);
        @(negedge clk);
        in_valid[idx] = 1'b0;
        inv_s[idx]    = ~iv;
        inp_data[idx] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Wait for out_valid; lat counts rising edges from the accept edge inclusive.
    task automatic collect(input int idx, output logic [127:0] res, output int lat);
        lat = 1;
        while (!out_valid[idx] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) check_int("collect_timeout", 1, 0);
        res = mixed_data[idx];
    endtask

    task automatic run_one(input int idx, input logic [127:0] d, input logic iv,
                           input logic [127:0] exp, input int exp_lat, input string name);
        logic [127:0] res;
        int lat;
        out_ready[idx] = 1'b1;
        send(idx, d, iv);
        collect(idx, res, lat);
        check({name, "_data"}, res, exp);
        check_int({name, "_latency"}, lat, exp_lat);
        @(negedge clk);
        check_int({name, "_idle_out_valid"}, int'(out_valid[idx]), 0);
        check_int({name, "_idle_in_ready"}, int'(in_ready[idx]), 1);
    endtask

    typedef struct {
        int           idx;
        logic [127:0] d;
        logic         iv;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [127:0] res;
        logic [127:0] held;
        logic [127:0] d;
        logic         iv;
        int           lat;
        bit           ok;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            inv_s[i]     = 1'b0;
            inp_data[i]  = '0;
            out_ready[i] = 1'b0;
        end

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_int("rst_out_valid", int'(out_valid[i]), 0);
            check_int("rst_in_ready", int'(in_ready[i]), 1);
            check("rst_mixed_data", mixed_data[i], 128'h0);
        end
        rst = 1'b0;
        @(negedge clk);

        // ---- table vectors ----
        vecs[0] = '{0, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                    128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 5};
        vecs[1] = '{0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1,
                    INV_EN ? 128'hdb135345_f20a225c_01010101_c6c6c6c6
                           : ref_mix(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0), 5};
        vecs[2] = '{1, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 1'b0,
                    128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 3};
        vecs[3] = '{2, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 1'b0,
                    128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 2};
        vecs[4] = '{2, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 1'b1,
                    INV_EN ? 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6
                           : ref_mix(128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 1'b0), 2};
        vecs[5] = '{1, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
                    128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 3};
        for (int v = 0; v < 6; v++)
            run_one(vecs[v].idx, vecs[v].d, vecs[v].iv, vecs[v].exp, vecs[v].lat,
                    $sformatf("vec%0d", v));

        // ---- randomized states with random backpressure ----
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 16; n++) begin
                d  = {$urandom(), $urandom(), $urandom(), $urandom()};
                iv = 1'($urandom_range(0, 1));
                exp_q.push_back(model(d, iv));
                out_ready[i] = 1'b0;
                send(i, d, iv);
                collect(i, res, lat);
                check_int("rand_latency", lat, 4 / cpc_of[i] + 1);
                check("rand_data", res, exp_q.pop_front());
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check("rand_hold", mixed_data[i], res);
                out_ready[i] = 1'b1;
                @(negedge clk);
                check_int("rand_idle", int'(in_ready[i]), 1);
            end
        end

        // ---- backpressure in DONE with in_valid pulses ----
        d = 128'h00112233_44556677_8899aabb_ccddeeff;
        out_ready[0] = 1'b0;
        send(0, d, 1'b0);
        collect(0, held, lat);
        check("bp_data", held, model(d, 1'b0));
        for (int k = 0; k < 10; k++) begin
            in_valid[0] = 1'($urandom_range(0, 1));
            inp_data[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(negedge clk);
            check_int("bp_out_valid", int'(out_valid[0]), 1);
            check_int("bp_in_ready", int'(in_ready[0]), 0);
            check("bp_stable", mixed_data[0], held);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check_int("bp_exit_out_valid", int'(out_valid[0]), 0);
        check_int("bp_exit_in_ready", int'(in_ready[0]), 1);

        // ---- reset in the second BUSY cycle ----
        d = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        send(0, d, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_int("midrst_out_valid", int'(out_valid[0]), 0);
        check_int("midrst_in_ready", int'(in_ready[0]), 1);
        check("midrst_mixed_data", mixed_data[0], 128'h0);
        rst = 1'b0;
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid[0]) ok = 1'b0;
        end
        check_int("midrst_no_out_valid", int'(ok), 1);
        run_one(0, d, 1'b0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 5, "after_rst");

        // ---- inv toggled in BUSY, in_valid held across DONE exit ----
        out_ready[1] = 1'b0;
        d = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
        in_valid[1] = 1'b1;
        inp_data[1] = d;
        inv_s[1]    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inv_s[1]    = 1'b0;
        inp_data[1] = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
        collect(1, res, lat);
        check("held_first_data", res, model(d, 1'b1));
        check_int("held_first_in_ready", int'(in_ready[1]), 0);
        out_ready[1] = 1'b1;
        @(negedge clk);
        check_int("held_exit_out_valid", int'(out_valid[1]), 0);
        check_int("held_exit_in_ready", int'(in_ready[1]), 1);
        @(negedge clk);
        check_int("held_second_accepted", int'(in_ready[1]), 0);
        in_valid[1] = 1'b0;
        collect(1, res, lat);
        check("held_second_data", res, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6);
        check_int("held_second_latency", lat, 3);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_columns_engine.md
MIX_COLUMNS_ENGINE -- requirements
Module: mix_columns_engine

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 1: columns transformed per cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1: input state offered.
REQ-005 SHALL have port in_ready  output  1: engine can accept a state.
REQ-006 SHALL have port inv  input  1: sampled with the input state; 1 = InvMixColumns, 0 = MixColumns.
REQ-007 SHALL have port inp_data  input  128: AES state; column c = bits [127-32c : 96-32c], row 0 byte in the top 8 bits of each column.
REQ-008 SHALL have port out_valid  output  1: mixed_data holds a finished result.
REQ-009 SHALL have port out_ready  input  1: downstream accepts result.
REQ-010 SHALL have port mixed_data  output  128: transformed state, same layout as inp_data.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 SHALL, in IDLE with in_valid=1, capture inp_data and inv into internal registers, clear column counter, go to BUSY.
REQ-013 SHALL, in BUSY, transform COLS_PER_CYCLE columns per cycle, column 0 first, writing results in place.
REQ-014 SHALL leave BUSY after 4/COLS_PER_CYCLE cycles; latency from accept edge to out_valid high = 4/COLS_PER_CYCLE + 1 cycles (5, 3, 2).
REQ-015 SHALL, in DONE, hold mixed_data and out_valid stable until out_ready=1, then return to IDLE on that edge.
REQ-016 SHALL NOT accept a new state in the cycle DONE is left (no back-to-back overlap); next accept earliest one cycle later.
REQ-017 SHALL compute forward column as GF(2^8) matrix [02 03 01 01] circulant, polynomial x^8+x^4+x^3+x+1.
REQ-018 SHALL compute inverse column as matrix [0e 0b 0d 09] circulant when inv=1 (see REQ-024).
REQ-019 SHALL ignore inp_data, inv and in_valid outside IDLE; changes to inv during BUSY SHALL not affect the result.
REQ-020 SHALL ignore out_ready outside DONE.

Reset
REQ-021 SHALL, with rst=1 at a clock edge, enter IDLE, clear column counter, drive out_valid=0, in_ready=1 on the following cycle, mixed_data=0.
REQ-022 SHALL, with rst asserted mid-BUSY or in DONE, discard the in-flight state without producing out_valid.
REQ-023 SHALL give rst priority over all simultaneous handshake events.

Configuration
REQ-024 SHALL compile the inverse datapath only when macro MIX_COLUMNS_INV_EN is defined; without it inv is ignored and every state receives forward MixColumns.

Verification
REQ-025 SHALL cover forward, COLS_PER_CYCLE=1: inp_data=db135345_f20a225c_01010101_c6c6c6c6, inv=0, out_ready=1 -> mixed_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid on 5th cycle after accept.
REQ-026 SHALL cover inverse (MIX_COLUMNS_INV_EN defined): inp_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, inv=1 -> mixed_data=db135345_f20a225c_01010101_c6c6c6c6; same vector without the macro -> forward result of that input.
REQ-027 SHALL cover latency for COLS_PER_CYCLE=2 and 4: column d4d4d4d5 in column 0 -> d5d5d7d6, column 2d26314c -> 4d7ebdf8; out_valid after 3 and 2 cycles respectively.
REQ-028 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and mixed_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-029 SHALL cover reset mid-BUSY: rst=1 in 2nd BUSY cycle -> next cycle out_valid=0, in_ready=1, mixed_data=0; following accept produces correct result.
REQ-030 SHALL cover inv toggled during BUSY and in_valid held high across DONE exit -> result per captured inv; second state accepted no earlier than one cycle after DONE exit.
